// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg - shared types for the LLC to AXI4-lite request bridge, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axi4_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_RESP  = 3'd4,
    ST_RSP_OUT  = 3'd5
  } bridge_state_t;

  // Request entry at the default bus widths; the bridge derives its own
  // parametrised copy with the same field order.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } axi_req_t;

  // SLVERR and DECERR both carry bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_req_fifo.sv
// ---------------------------------------------------------------------------
// axi_req_fifo - in-order synchronous request FIFO with occupancy, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_req_fifo
  import axi4_lite_pkg::*;
#(
  parameter type         T     = axi_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi4_lite_req_bridge.sv
// ---------------------------------------------------------------------------
// axi4_lite_req_bridge - LLC requests to single-outstanding AXI4-lite master, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi4_lite_req_bridge
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [DATA_WIDTH/8-1:0]       req_wstrb,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_write,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic [$clog2(REQ_DEPTH):0]    req_count,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         AWADDR,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [DATA_WIDTH-1:0]         WDATA,
  output logic [DATA_WIDTH/8-1:0]       WSTRB,
  output logic                          WVALID,
  input  logic                          WREADY,
  input  logic [1:0]                    BRESP,
  input  logic                          BVALID,
  output logic                          BREADY,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RVALID,
  output logic                          RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
  } req_t;

  req_t                  w_push_data;
  req_t                  w_head;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_cap_err;

  bridge_state_t         r_state;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  r_bready;
  logic                  r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_resp_valid;
  logic                  r_resp_write;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;
  logic [ERR_CNT_W-1:0]  r_err_count;

  assign w_push_data = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // Ready is forced low while reset is held, independent of occupancy.
  assign req_ready = rst_n && !w_fifo_full;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_fifo_empty;

  axi_req_fifo #(
    .T     (req_t),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (req_count)
  );

  // A channel is done once its valid has dropped or is being accepted now.
  assign w_aw_done = !r_awvalid || AWREADY;
  assign w_w_done  = !r_wvalid  || WREADY;

  assign w_cap_err = ((r_state == ST_WR_RESP) && BVALID && resp_is_err(BRESP)) ||
                     ((r_state == ST_RD_RESP) && RVALID && resp_is_err(RRESP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_araddr     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_head.write) begin
              r_awaddr  <= w_head.addr;
              r_wdata   <= w_head.wdata;
              r_wstrb   <= w_head.wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_araddr  <= w_head.addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end
        end

        ST_WR_REQ: begin
          if (r_awvalid && AWREADY) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && WREADY) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (BVALID) begin
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= resp_is_err(BRESP);
            r_state      <= ST_RSP_OUT;
          end
        end

        ST_RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_RESP;
          end
        end

        ST_RD_RESP: begin
          if (RVALID) begin
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b0;
            r_resp_rdata <= RDATA;
            r_resp_err   <= resp_is_err(RRESP);
            r_state      <= ST_RSP_OUT;
          end
        end

        ST_RSP_OUT: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_cap_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign AWADDR     = r_awaddr;
  assign AWVALID    = r_awvalid;
  assign WDATA      = r_wdata;
  assign WSTRB      = r_wstrb;
  assign WVALID     = r_wvalid;
  assign BREADY     = r_bready;
  assign ARADDR     = r_araddr;
  assign ARVALID    = r_arvalid;
  assign RREADY     = r_rready;
  assign resp_valid = r_resp_valid;
  assign resp_write = r_resp_write;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign err_count  = r_err_count;
  assign busy       = (r_state != ST_IDLE) || (req_count != '0);

endmodule

`default_nettype wire
